// File: rtl/ddr2_init_monitor.sv
// Passive checker for the DDR2 power-up/init command stream. It enforces the init
// command order and minimum spacing, captures the mode registers and reports done or a sticky error.
module ddr2_init_monitor #(
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned ADDR_BITS = 13,
  parameter int unsigned TSTAB_CK  = 100,
  parameter int unsigned TRP_CK    = 3,
  parameter int unsigned TMRD_CK   = 2,
  parameter int unsigned TRFC_CK   = 26
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic [3:0]           cmd,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 init_done,
  output logic                 init_err,
  output logic [2:0]           err_code,
  output logic [3:0]           step,
  output logic [ADDR_BITS-1:0] mr_q,
  output logic [ADDR_BITS-1:0] emr1_q,
  output logic [ADDR_BITS-1:0] emr2_q,
  output logic [ADDR_BITS-1:0] emr3_q
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned CODE_W = 3;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LM   = 4'b0000;

  localparam logic [CODE_W-1:0] ERR_NONE  = CODE_W'(0);
  localparam logic [CODE_W-1:0] ERR_EARLY = CODE_W'(1);
  localparam logic [CODE_W-1:0] ERR_ORDER = CODE_W'(2);
  localparam logic [CODE_W-1:0] ERR_TIME  = CODE_W'(3);
  localparam logic [CODE_W-1:0] ERR_CKE   = CODE_W'(4);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(10);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_STAB,
    ST_SEQ,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    PV_PRE,
    PV_LM,
    PV_AREF
  } prev_e;

  state_e                state_q, state_d;
  prev_e                 prev_q, prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [ADDR_BITS-1:0]  mr_d, emr1_d, emr2_d, emr3_d;

  logic                  is_cmd_c;
  logic                  is_pre_c;
  logic                  is_aref_c;
  logic                  is_lm_c;
  logic                  match_c;
  logic [CNT_W-1:0]      min_gap_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  raise_c;
  logic [CODE_W-1:0]     raise_code_c;
  logic                  accept_c;

  // Command decode; cs_n high is a deselect and behaves as NOP.
  always_comb begin
    is_cmd_c  = (cmd[3] == 1'b0) && (cmd != CMD_NOP);
    is_pre_c  = (cmd == CMD_PRE);
    is_aref_c = (cmd == CMD_AREF);
    is_lm_c   = (cmd == CMD_LM);
  end

  // Expected command for the current step.
  always_comb begin
    match_c = 1'b0;
    unique case (step_q)
      STEP_W'(0), STEP_W'(5): match_c = is_pre_c && addr[10];
      STEP_W'(1):             match_c = is_lm_c && (ba == BA_BITS'(2));
      STEP_W'(2):             match_c = is_lm_c && (ba == BA_BITS'(3));
      STEP_W'(3):             match_c = is_lm_c && (ba == BA_BITS'(1));
      STEP_W'(4):             match_c = is_lm_c && (ba == BA_BITS'(0)) && addr[8];
      STEP_W'(6), STEP_W'(7): match_c = is_aref_c;
      STEP_W'(8):             match_c = is_lm_c && (ba == BA_BITS'(0)) && !addr[8];
      STEP_W'(9):             match_c = is_lm_c && (ba == BA_BITS'(1)) && (addr[9:7] == 3'b111);
      STEP_W'(10):            match_c = is_lm_c && (ba == BA_BITS'(1)) && (addr[9:7] == 3'b000);
      default:                match_c = 1'b0;
    endcase
  end

  // Minimum spacing is set by the type of the previously accepted command.
  always_comb begin
    min_gap_c = CNT_W'(TMRD_CK);
    unique case (prev_q)
      PV_PRE:  min_gap_c = CNT_W'(TRP_CK);
      PV_LM:   min_gap_c = CNT_W'(TMRD_CK);
      PV_AREF: min_gap_c = CNT_W'(TRFC_CK);
      default: min_gap_c = CNT_W'(TMRD_CK);
    endcase
  end

  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic. cnt is cycles since cke rise in STAB and the command gap in SEQ.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    done_d       = done_q;
    err_d        = err_q;
    code_d       = code_q;
    mr_d         = mr_q;
    emr1_d       = emr1_q;
    emr2_d       = emr2_q;
    emr3_d       = emr3_q;
    raise_c      = 1'b0;
    raise_code_c = ERR_NONE;
    accept_c     = 1'b0;

    unique case (state_q)
      ST_PWRUP: begin
        cnt_d = '0;
        if (is_cmd_c) begin
          raise_c      = 1'b1;
          raise_code_c = ERR_EARLY;
        end else if (cke) begin
          state_d = ST_STAB;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_STAB: begin
        if (!cke) begin
          raise_c      = 1'b1;
          raise_code_c = ERR_CKE;
        end else if (is_cmd_c) begin
          if (cnt_q < CNT_W'(TSTAB_CK)) begin
            raise_c      = 1'b1;
            raise_code_c = ERR_EARLY;
          end else if (!match_c) begin
            raise_c      = 1'b1;
            raise_code_c = ERR_ORDER;
          end else begin
            accept_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      ST_SEQ: begin
        if (!cke) begin
          raise_c      = 1'b1;
          raise_code_c = ERR_CKE;
        end else if (is_cmd_c) begin
          if (cnt_q < min_gap_c) begin
            raise_c      = 1'b1;
            raise_code_c = ERR_TIME;
          end else if (!match_c) begin
            raise_c      = 1'b1;
            raise_code_c = ERR_ORDER;
          end else begin
            accept_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      default: ;
    endcase

    if (raise_c) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      code_d  = raise_code_c;
    end else if (accept_c) begin
      step_d = step_q + STEP_W'(1);
      cnt_d  = CNT_W'(1);
      if (is_pre_c) begin
        prev_d = PV_PRE;
      end else if (is_aref_c) begin
        prev_d = PV_AREF;
      end else begin
        prev_d = PV_LM;
      end
      if (is_lm_c) begin
        if (ba == BA_BITS'(0)) begin
          mr_d = addr;
        end else if (ba == BA_BITS'(1)) begin
          emr1_d = addr;
        end else if (ba == BA_BITS'(2)) begin
          emr2_d = addr;
        end else if (ba == BA_BITS'(3)) begin
          emr3_d = addr;
        end
      end
      if (step_q == LAST_STEP) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_SEQ;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRUP;
      prev_q  <= PV_PRE;
      cnt_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      mr_q    <= '0;
      emr1_q  <= '0;
      emr2_q  <= '0;
      emr3_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      mr_q    <= mr_d;
      emr1_q  <= emr1_d;
      emr2_q  <= emr2_d;
      emr3_q  <= emr3_d;
    end
  end

  assign init_done = done_q;
  assign init_err  = err_q;
  assign err_code  = code_q;
  assign step      = step_q;

endmodule
